// File: rtl/rpn_entry_player.sv
// rpn_entry_player: replays one RPN calculation (A, B, Op, Return) as held, debounced presses.
// Build option: define RPN_PLAYER_STATUS_CHECK_EN to confirm each press via status_in with a timeout.
module rpn_entry_player #(
  parameter int HOLD_CYCLES    = 12,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] display_in,
  input  logic [3:0]        flags_in,
  input  logic [2:0]        status_in,
  output logic [DATA_W-1:0] data_out,
  output logic              enter_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        result_flags,
  output logic [1:0]        phase
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] PH_A   = 2'd0;
  localparam logic [1:0] PH_B   = 2'd1;
  localparam logic [1:0] PH_OP  = 2'd2;
  localparam logic [1:0] PH_RET = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRESS,
    S_GAP,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_phase;
  logic [1:0]        w_next_phase;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic              r_enter;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_result_flags;
  logic [DATA_W-1:0] w_load_data;
  logic              w_accept;
  logic              w_capture;
  logic              w_ack_seen;
  logic              w_wait_expired;

  assign w_accept = (r_state == S_IDLE) && start;

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD;
          w_next_phase = PH_A;
        end
      end
      S_LOAD:  w_next_state = S_PRESS;
      S_PRESS: if (r_cnt == HOLD_LAST) w_next_state = S_GAP;
      S_GAP:   if (r_cnt == GAP_LAST) w_next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (w_ack_seen) begin
          w_capture = (r_phase == PH_OP);
          if (r_phase == PH_RET) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_LOAD;
            w_next_phase = r_phase + 2'd1;
          end
        end else if (w_wait_expired) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Phase A is only ever loaded straight out of IDLE, before r_a has captured op_a.
  always_comb begin
    w_load_data = '0;
    case (w_next_phase)
      PH_A:    w_load_data = (r_state == S_IDLE) ? op_a : r_a;
      PH_B:    w_load_data = r_b;
      PH_OP:   w_load_data = {{(DATA_W-2){1'b0}}, r_op};
      default: w_load_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_phase        <= PH_A;
      r_cnt          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_data         <= '0;
      r_enter        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_result_flags <= '0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_enter <= (w_next_state == S_PRESS);
      r_done  <= (w_next_state == S_DONE);

      if (w_next_state != r_state) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_a    <= op_a;
        r_b    <= op_b;
        r_op   <= op_code;
        r_busy <= 1'b1;
      end else if (w_next_state == S_DONE) begin
        r_busy <= 1'b0;
      end

      if (w_next_state == S_LOAD) r_data <= w_load_data;

      if (w_capture) begin
        r_result       <= display_in;
        r_result_flags <= flags_in;
      end
    end
  end

`ifdef RPN_PLAYER_STATUS_CHECK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] r_snap;
  logic       r_ack;
  logic       r_err;

  // The ack flag is sticky from PRESS onward so a fast calculator response is not missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (r_state == S_WAIT_ACK && !w_ack_seen && w_wait_expired) begin
        r_err <= 1'b1;
      end

      if (r_state == S_LOAD) begin
        r_snap <= status_in;
        r_ack  <= 1'b0;
      end else if ((r_state inside {S_PRESS, S_GAP, S_WAIT_ACK}) && (status_in != r_snap)) begin
        r_ack <= 1'b1;
      end
    end
  end

  assign w_ack_seen     = r_ack || (status_in != r_snap);
  assign w_wait_expired = (r_cnt == TIMEOUT_LAST);
  assign err            = r_err;
`else
  logic w_unused_status;

  assign w_unused_status = ^status_in;
  assign w_ack_seen      = 1'b1;
  assign w_wait_expired  = 1'b0;
  assign err             = 1'b0;
`endif

  assign data_out     = r_data;
  assign enter_out    = r_enter;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign result_flags = r_result_flags;
  assign phase        = r_phase;

endmodule

// File: tb/tb_rpn_entry_player.sv
// tb_rpn_entry_player: randomized runs against a behavioural calculator stub and reference model.
// Expectations follow the RPN_PLAYER_STATUS_CHECK_EN build option when it is defined.
`timescale 1ns/1ps
module tb_rpn_entry_player;

  localparam int HOLD     = 12;
  localparam int GAP      = 4;
  localparam int TIMEOUT  = 64;
  localparam int DEBOUNCE = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_code;
  logic [15:0] display_in = '0;
  logic [3:0]  flags_in = '0;
  logic [2:0]  status_in = '0;
  logic [15:0] data_out;
  logic        enter_out, busy, done, err;
  logic [15:0] result;
  logic [3:0]  result_flags;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;

  int stub_delay  = 0;
  bit stub_frozen = 1'b0;

  rpn_entry_player #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .DATA_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .display_in(display_in), .flags_in(flags_in), .status_in(status_in),
    .data_out(data_out), .enter_out(enter_out), .busy(busy), .done(done), .err(err),
    .result(result), .result_flags(result_flags), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Calculator ALU as seen on the display: result and flags {N,Z,C,V}.
  function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2:    r = a | b;
      default: r = a & b;
    endcase
    return {r, r[15], (r == 16'h0), c, v};
  endfunction

  // Calculator stub: registers a press after DEBOUNCE high cycles, bumps status after stub_delay.
  int          stub_cnt = 0;
  int          stub_idx = 0;
  int          stub_countdown = -1;
  logic [15:0] stub_vals [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt       = 0;
      stub_idx       = 0;
      stub_countdown = -1;
    end else begin
      if (stub_countdown > 0) stub_countdown--;
      else if (stub_countdown == 0) begin
        status_in <= status_in + 3'd1;
        stub_countdown = -1;
      end
      if (!busy) stub_idx = 0;
      if (enter_out) begin
        stub_cnt++;
        if (stub_cnt == DEBOUNCE) begin
          if (stub_idx < 3) stub_vals[stub_idx] = data_out;
          if (stub_idx == 2) {display_in, flags_in} <= alu(stub_vals[0], stub_vals[1], stub_vals[2][1:0]);
          if (stub_idx == 3) display_in <= ~display_in;
          stub_idx = (stub_idx + 1) % 4;
          if (!stub_frozen) stub_countdown = stub_delay;
        end
      end else begin
        stub_cnt = 0;
      end
    end
  end

  // Watches one run from the cycle after start was accepted until done, then one cycle more.
  task automatic monitor_run(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                             input bit spur, input bit frozen);
    logic [15:0] exp_data [4];
    logic [19:0] exp_alu;
    logic        prev_enter;
    logic [15:0] prev_data;
    int          hold_cnt, low_cnt, pulses, busy_cnt;
    bit          seen_done, expect_to, exact_len;
    exp_data[0] = a;
    exp_data[1] = b;
    exp_data[2] = {14'b0, op};
    exp_data[3] = 16'h0;
    exp_alu     = alu(a, b, op);
    expect_to   = 1'b0;
    exact_len   = 1'b1;
`ifdef RPN_PLAYER_STATUS_CHECK_EN
    expect_to   = frozen;
    exact_len   = (stub_delay == 0);
`endif
    prev_enter = 1'b0;
    prev_data  = data_out;
    hold_cnt   = 0;
    low_cnt    = 0;
    pulses     = 0;
    busy_cnt   = 1;
    seen_done  = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
      @(negedge clk);
      if (spur && cyc == 30) begin
        start   = 1'b1;
        op_a    = ~a;
        op_b    = ~b;
        op_code = ~op;
      end else if (spur && cyc == 31) begin
        start = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_enter", enter_out, 0);
        check("done_busy", busy, 0);
      end else begin
        if (busy) busy_cnt++;
        if (enter_out && !prev_enter) begin
          if (pulses < 4) check("data_seq", data_out, exp_data[pulses]);
          check("data_setup", prev_data, data_out);
          if (pulses > 0) check("gap_min", (low_cnt >= GAP), 1);
          pulses++;
          hold_cnt = 0;
        end
        if (!enter_out && prev_enter) begin
          check("hold_len", hold_cnt, HOLD);
          low_cnt = 0;
        end
        if (enter_out) hold_cnt++;
        else           low_cnt++;
      end
      prev_enter = enter_out;
      prev_data  = data_out;
    end
    check("done_seen", seen_done, 1);
    if (expect_to) begin
      check("to_pulses", pulses, 1);
      check("to_err", err, 1);
      check("to_phase", phase, 0);
      check("to_len", busy_cnt, 1 + HOLD + GAP + TIMEOUT);
    end else begin
      check("pulses", pulses, 4);
      check("err", err, 0);
      check("phase_end", phase, 3);
      check("result", result, exp_alu[19:4]);
      check("result_flags", result_flags, exp_alu[3:0]);
      if (exact_len) check("run_len", busy_cnt, 4 * (2 + HOLD + GAP));
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          input bit spur, input bit frozen);
    @(negedge clk);
    op_a    = a;
    op_b    = b;
    op_code = op;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    op_a    = 16'($urandom);
    op_b    = 16'($urandom);
    op_code = 2'($urandom_range(3, 0));
    monitor_run(a, b, op, spur, frozen);
  endtask

  initial begin
    bit found;
    reset   = 1'b1;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    op_code = '0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_enter", enter_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_flags", result_flags, 0);
    check("rst_phase", phase, 0);
    reset = 1'b0;

    run_calc(16'hFFFF, 16'h0101, 2'd0, 1'b0, 1'b0);
    check("tp_add_result", result, 16'h0100);
    check("tp_add_flags", result_flags, 4'b0010);
    run_calc(16'hFFFF, 16'h0101, 2'd1, 1'b0, 1'b0);
    check("tp_sub_result", result, 16'hFEFE);
    check("tp_sub_n", result_flags[3], 1);
    check("tp_sub_z", result_flags[2], 0);
    run_calc(16'hFFFF, 16'h0101, 2'd2, 1'b0, 1'b0);
    check("tp_or_result", result, 16'hFFFF);
    check("tp_or_n", result_flags[3], 1);
    run_calc(16'hFFFF, 16'h0003, 2'd3, 1'b0, 1'b0);
    check("tp_and_result", result, 16'h0003);
    check("tp_and_nz", result_flags[3:2], 0);

    for (int i = 0; i < 8; i++) begin
      stub_delay = $urandom_range(30, 0);
      run_calc(16'($urandom), 16'($urandom), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0);
    end
    stub_delay = 0;

    // start held across DONE restarts on the first IDLE cycle
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; op_code = 2'd0; start = 1'b1;
    @(negedge clk);
    check("b2b_busy1", busy, 1);
    op_a = 16'h0F0F; op_b = 16'h00FF; op_code = 2'd3;
    monitor_run(16'h1111, 16'h2222, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_restart", busy, 1);
    start = 1'b0;
    op_a  = 16'($urandom);
    monitor_run(16'h0F0F, 16'h00FF, 2'd3, 1'b0, 1'b0);

    // asynchronous reset in the middle of the B press
    @(negedge clk);
    op_a = 16'hA5A5; op_b = 16'h5A5A; op_code = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (phase == 2'd1 && enter_out) found = 1'b1;
    end
    check("reach_phase1", found, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_enter", enter_out, 0);
    check("arst_busy", busy, 0);
    check("arst_data", data_out, 0);
    check("arst_phase", phase, 0);
    @(negedge clk);
    reset = 1'b0;
    run_calc(16'h1234, 16'h4321, 2'd0, 1'b0, 1'b0);

    // calculator that never answers
    stub_frozen = 1'b1;
    run_calc(16'h0007, 16'h0009, 2'd1, 1'b0, 1'b1);
    stub_frozen = 1'b0;
    run_calc(16'h8000, 16'h8000, 2'd0, 1'b0, 1'b0);
    check("err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_entry_player.md
Name: rpn_entry_player

Overview:
- Hardware stimulus source for the RPN calculator top. It drives the calculator's Enter/DataIn inputs and reads back its display, flag and status outputs.
- On a start request it plays one full calculation as four timed button presses: A, B, Op, then Return.
- Each press is held long enough to pass the calculator's debouncer. The player confirms each press through the calculator's Status output.
- It captures the displayed result and flags after the Op press. Used for on-board self-test and as a bench driver.

Parameters:
HOLD_CYCLES, 12, clock cycles enter_out is held high per press (must exceed calculator debounce time)
GAP_CYCLES, 4, minimum low cycles after each release before the next press
TIMEOUT_CYCLES, 64, cycles allowed after release for status_in to change before aborting
DATA_W, 16, operand/result width

Ports:
clk  in  1  system clock
reset  in  1  reset: one clock; reset is asynchronous and active-high
start  in  1  request one calculation; sampled only in IDLE
op_a  in  DATA_W  operand A, latched on accepted start
op_b  in  DATA_W  operand B, latched on accepted start
op_code  in  2  0 add, 1 sub, 2 OR, 3 AND; latched on accepted start
display_in  in  DATA_W  calculator ToDisplay
flags_in  in  4  calculator Flags {N,Z,C,V}
status_in  in  3  calculator Status
data_out  out  DATA_W  to calculator DataIn
enter_out  out  1  to calculator Enter
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of a run (success or abort)
err  out  1  set on timeout abort, cleared on next accepted start
result  out  DATA_W  captured display_in after Op press
result_flags  out  4  captured flags_in after Op press
phase  out  2  current press: 0 A, 1 B, 2 Op, 3 Return

Behaviour:
- Reset (async, immediate):
  - all outputs 0, enter_out dropped at once
  - FSM goes to IDLE, phase=0
  - latched operands cleared
- States: IDLE, LOAD, PRESS, GAP, WAIT_ACK, DONE.
- IDLE:
  - start=1 latches op_a/op_b/op_code, sets busy, clears err, sets phase=0, goes to LOAD
  - start while busy is ignored
- LOAD (1 cycle):
  - data_out set to the phase value: A, B, {14'b0,op_code}, or 0 for Return
  - status_in snapshot stored, ack flag cleared
  - data_out stays stable until the next LOAD, so it is valid at least one cycle before enter_out rises
- PRESS: enter_out=1 for exactly HOLD_CYCLES cycles, then GAP.
- GAP: enter_out=0 for GAP_CYCLES cycles, then WAIT_ACK.
- Ack:
  - the ack flag is sticky; it sets whenever status_in differs from the snapshot, at any cycle from PRESS onward
  - WAIT_ACK proceeds the first cycle ack=1 (zero extra cycles if ack was already seen)
  - otherwise WAIT_ACK counts TIMEOUT_CYCLES; on expiry: err=1, enter_out=0, go to DONE
  - phase holds the failing press for debug
- On ack in phase 2: result<=display_in and result_flags<=flags_in in that cycle.
- After ack: phase 0-2 increments and returns to LOAD; phase 3 goes to DONE.
- DONE:
  - done=1 for one cycle, busy=0, return to IDLE
  - result/result_flags/err held until the next accepted start
- Nominal run length: 4 x (1 + HOLD_CYCLES + GAP_CYCLES) + ack waits + 1.
- Counters: $clog2-sized, reset to 0 on every state entry.
- start held high across DONE starts a new run on the first IDLE cycle.

Optional Feature:
- Macro: RPN_PLAYER_STATUS_CHECK_EN.
- Defined: status_in snapshot/ack/timeout logic as described.
- Undefined:
  - status_in is ignored and WAIT_ACK lasts a fixed 1 cycle
  - err is tied to 0
  - capture occurs on that cycle in phase 2

Test Plan:
- Reset, start with A=0xFFFF, B=0x0101, op=0 against calculator (N_DEBOUNCER=10) -> four enter pulses of 12 cycles each; data_out sequence FFFF, 0101, 0000, 0000; result=0x0100, result_flags=4'b0010; done pulse, err=0.
- A=0xFFFF, B=0x0101, op=1 -> result=0xFEFE, result_flags[3]=1 (N), Z=0.
- A=0xFFFF, B=0x0101, op=2 -> result=0xFFFF, N=1; then op=3 with B=0x0003 -> result=0x0003, flags N=0, Z=0.
- Stub with status_in frozen, macro defined -> first press times out 64 cycles after GAP; err=1, phase=0, done pulses, enter_out low; macro undefined -> run completes, err=0.
- Assert reset mid-PRESS of phase 1 -> enter_out, busy, data_out go 0 same time step; next start runs cleanly from phase 0.
- Pulse start while busy -> ignored, latched operands unchanged; hold start through DONE -> back-to-back run begins on next IDLE cycle.
